pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central sequencing controller for the 5-stage in-order pipeline.
- Drives write-enable and flush for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the operand forwarding selects.
- Resolves, in priority order: halt, LSU wait, multi-cycle EXU busy, branch redirect, load-use hazard.
- Tracks halt/error state and keeps retire/stall performance counters.

Parameters:
CNT_W, 64, width of retire_cnt and stall_cnt.
LSU_TIMEOUT, 1024, maximum cycles waiting on lsu_done before entering ERR.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset; synchronous, active-low.
id_valid  in  1  IF/ID holds a valid instruction.
id_rs1, id_rs2  in  5  ID source register indices.
id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1 / rs2.
ex_valid  in  1  ID/EX register valid.
ex_rd  in  5  EX destination register.
ex_rd_w_en  in  1  EX writes rd.
ex_is_load  in  1  EX instruction is a load.
ex_busy  in  1  multi-cycle EXU op (mul/div) not finished.
ex_branch_taken  in  1  EX resolved a taken branch or jump.
mem_valid  in  1  EX/MEM register valid.
mem_rd  in  5  MEM destination register.
mem_rd_w_en  in  1  MEM writes rd.
mem_lsu_req  in  1  MEM instruction accesses memory.
lsu_done  in  1  LSU access complete this cycle.
wb_valid  in  1  MEM/WB register valid.
wb_ebreak  in  1  WB instruction is ebreak.
pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen  out  1  register write enables.
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  clear the target valid bit on the next edge; overrides wen.
fwd_rs1_sel, fwd_rs2_sel  out  2  operand source: 00 regfile, 01 EX result, 10 MEM result.
halted  out  1  core stopped by ebreak.
err  out  1  LSU timeout.
retire_cnt  out  CNT_W  retired instruction count.
stall_cnt  out  CNT_W  stalled cycle count.

Behaviour:
- Reset (rst=0 at an edge):
  - state=RUN; retire_cnt=0, stall_cnt=0, halted=0, err=0; timeout counter=0.
  - While rst=0: all wen=0, all flushes=1, fwd selects=00.
- Internal conditions, all combinational:
  - lsu_stall = mem_valid & mem_lsu_req & ~lsu_done.
  - exu_stall = ex_valid & ex_busy.
  - load_use = id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - redirect = ex_valid & ex_branch_taken.
- Default (RUN, no condition active): all wen=1, all flush=0.
- Conditions, highest priority first; only the highest active one applies:
  1. state HALT or ERR: all wen=0, all flushes=1.
  2. lsu_stall: pc/if_id/id_ex/ex_mem wen=0; mem_wb_flush=1 (bubble into WB).
  3. exu_stall: pc/if_id/id_ex wen=0; ex_mem_flush=1; mem_wb_wen=1.
  4. redirect: pc_wen=1 (loads target); if_id_flush=1, id_ex_flush=1; others wen=1.
  5. load_use: pc/if_id wen=0; id_ex_flush=1; ex_mem/mem_wb wen=1.
- FSM:
  - RUN->LSU_WAIT when lsu_stall.
  - LSU_WAIT->RUN on lsu_done. If lsu_done is already high in the same cycle as the request, stay in RUN (zero-wait access).
  - LSU_WAIT->ERR when the timeout counter reaches LSU_TIMEOUT-1 without lsu_done. The counter increments each LSU_WAIT cycle and clears on leaving LSU_WAIT.
  - Any non-HALT/ERR state->HALT when wb_valid & wb_ebreak. This takes precedence over LSU transitions.
  - HALT and ERR are terminal until reset. halted=1 in HALT, err=1 in ERR, both registered.
- Forwarding, per rs (x = rs1/rs2):
  - 01 if ex_valid & ex_rd_w_en & ~ex_is_load & ex_rd!=0 & ex_rd==id_rsx.
  - else 10 if mem_valid & mem_rd_w_en & mem_rd!=0 & mem_rd==id_rsx.
  - else 00.
  - EX beats MEM when both match. Register 0 never forwards.
- Counters:
  - retire_cnt += 1 each edge with wb_valid=1 in RUN or LSU_WAIT, including the ebreak instruction itself.
  - stall_cnt += 1 each edge with pc_wen=0 in RUN or LSU_WAIT.
  - Both wrap modulo 2^CNT_W and freeze in HALT/ERR.
- Reset mid-stall or in HALT/ERR returns to RUN on the next edge. In-flight LSU status is discarded.

Test Plan:
1. Load-use: EX load rd=5, ID uses rs1=5 -> one cycle with pc_wen=0, if_id_wen=0, id_ex_flush=1; next cycle fwd_rs1_sel=10; stall_cnt=1.
2. Back-to-back ALU: EX rd=3, MEM rd=3, ID rs2=3 -> fwd_rs2_sel=01. With rd=0 in both -> 00.
3. LSU wait: mem_lsu_req, lsu_done low 3 cycles then high -> 3 cycles pc_wen=0 and mem_wb_flush=1; FSM RUN->LSU_WAIT->RUN; stall_cnt=3.
4. Simultaneous: lsu_stall with ex_branch_taken -> no redirect until lsu_done; on that cycle pc_wen=1, if_id_flush=1, id_ex_flush=1.
5. Timeout: LSU_TIMEOUT=8, lsu_done never asserted -> err=1 after 8 stall cycles; all wen=0; counters frozen; rst=0 for one edge -> err=0, state RUN, counters 0.
6. Ebreak: 10 instructions retired, then wb_ebreak -> retire_cnt=11, halted=1, all flushes=1 thereafter; exu_busy/lsu inputs ignored.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the 5-stage in-order pipeline.
// Produces per-register write enables and flushes, operand forwarding
// selects, halt/error status and retire/stall performance counters.
module pipe_ctrl #(
  parameter int CNT_W       = 64,
  parameter int LSU_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rd_w_en,
  input  logic             ex_is_load,
  input  logic             ex_busy,
  input  logic             ex_branch_taken,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rd_w_en,
  input  logic             mem_lsu_req,
  input  logic             lsu_done,
  input  logic             wb_valid,
  input  logic             wb_ebreak,
  output logic             pc_wen,
  output logic             if_id_wen,
  output logic             id_ex_wen,
  output logic             ex_mem_wen,
  output logic             mem_wb_wen,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TMO_W = $clog2(LSU_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LSU_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LSU_WAIT = 2'd1,
    ST_HALT     = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               halted_q, halted_d;
  logic               err_q, err_d;

  logic lsu_stall, exu_stall, load_use, redirect;
  logic active;

  // Hazard conditions decoded from the pipeline register status
  always_comb begin
    lsu_stall = mem_valid & mem_lsu_req & ~lsu_done;
    exu_stall = ex_valid & ex_busy;
    load_use  = id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) |
                 (id_use_rs2 & (id_rs2 == ex_rd)));
    redirect  = ex_valid & ex_branch_taken;
    active    = (state_q == ST_RUN) || (state_q == ST_LSU_WAIT);
  end

  // Priority-resolved write enables and flushes; only the top condition applies
  always_comb begin
    pc_wen       = 1'b1;
    if_id_wen    = 1'b1;
    id_ex_wen    = 1'b1;
    ex_mem_wen   = 1'b1;
    mem_wb_wen   = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst || !active) begin
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      id_ex_wen    = 1'b0;
      ex_mem_wen   = 1'b0;
      mem_wb_wen   = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (lsu_stall) begin
      // Freeze everything up to MEM and bubble WB
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      id_ex_wen    = 1'b0;
      ex_mem_wen   = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (exu_stall) begin
      // Hold front end while EX iterates; let MEM drain into WB
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      id_ex_wen    = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (redirect) begin
      // PC loads the branch target; squash the two younger instructions
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      // Hold the consumer in ID one cycle, insert a bubble into EX
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  // Operand forwarding selects; the younger EX result wins over MEM, x0 never forwards
  always_comb begin
    fwd_rs1_sel = 2'b00;
    fwd_rs2_sel = 2'b00;
    if (rst) begin
      if (ex_valid && ex_rd_w_en && !ex_is_load && ex_rd != 5'd0 && ex_rd == id_rs1)
        fwd_rs1_sel = 2'b01;
      else if (mem_valid && mem_rd_w_en && mem_rd != 5'd0 && mem_rd == id_rs1)
        fwd_rs1_sel = 2'b10;
      if (ex_valid && ex_rd_w_en && !ex_is_load && ex_rd != 5'd0 && ex_rd == id_rs2)
        fwd_rs2_sel = 2'b01;
      else if (mem_valid && mem_rd_w_en && mem_rd != 5'd0 && mem_rd == id_rs2)
        fwd_rs2_sel = 2'b10;
    end
  end

  // Next state, LSU timeout tracking and counter updates
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    case (state_q)
      ST_RUN: begin
        if (lsu_stall) state_d = ST_LSU_WAIT;
      end
      ST_LSU_WAIT: begin
        if (lsu_done) begin
          state_d = ST_RUN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_LAST) state_d = ST_ERR;
        end
      end
      default: state_d = state_q;
    endcase
    // An ebreak reaching WB stops the core regardless of LSU progress
    if (active && wb_valid && wb_ebreak) state_d = ST_HALT;
    if (state_d != ST_LSU_WAIT) tmo_d = '0;

    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (active && wb_valid) retire_cnt_d = retire_cnt_q + CNT_W'(1);
    if (active && !pc_wen)  stall_cnt_d  = stall_cnt_q + CNT_W'(1);

    halted_d = (state_d == ST_HALT);
    err_d    = (state_d == ST_ERR);
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      tmo_q        <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
    end
  end

  assign halted     = halted_q;
  assign err        = err_q;
  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_rd_w_en, ex_is_load, ex_busy, ex_branch_taken;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic        mem_rd_w_en, mem_lsu_req, lsu_done;
  logic        wb_valid, wb_ebreak;
  logic        pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic        halted, err;
  logic [63:0] retire_cnt, stall_cnt;

  logic [4:0]  wens;
  logic [3:0]  flushes;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.CNT_W(64), .LSU_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rd_w_en(ex_rd_w_en),
    .ex_is_load(ex_is_load), .ex_busy(ex_busy), .ex_branch_taken(ex_branch_taken),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_rd_w_en(mem_rd_w_en),
    .mem_lsu_req(mem_lsu_req), .lsu_done(lsu_done),
    .wb_valid(wb_valid), .wb_ebreak(wb_ebreak),
    .pc_wen(pc_wen), .if_id_wen(if_id_wen), .id_ex_wen(id_ex_wen),
    .ex_mem_wen(ex_mem_wen), .mem_wb_wen(mem_wb_wen),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .halted(halted), .err(err),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  assign wens    = {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen};
  assign flushes = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_rd_w_en = 0; ex_is_load = 0; ex_busy = 0;
    ex_branch_taken = 0;
    mem_valid = 0; mem_rd = 0; mem_rd_w_en = 0; mem_lsu_req = 0; lsu_done = 0;
    wb_valid = 0; wb_ebreak = 0;
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle after an input change
  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    step();
    step();
    // Reset behaviour
    settle();
    chk("rst_wens", 64'(wens), 64'b00000);
    chk("rst_flush", 64'(flushes), 64'b1111);
    chk("rst_fwd", 64'({fwd_rs1_sel, fwd_rs2_sel}), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_retire", retire_cnt, 64'd0);
    chk("rst_stall", stall_cnt, 64'd0);
    rst = 1'b1;
    step();
    settle();
    chk("run_idle_wens", 64'(wens), 64'b11111);
    chk("run_idle_flush", 64'(flushes), 64'b0000);

    // 1. Load-use: EX load x5, ID reads x5
    step();
    idle();
    id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
    ex_valid = 1; ex_rd = 5; ex_rd_w_en = 1; ex_is_load = 1;
    settle();
    chk("lu_wens", 64'(wens), 64'b00111);
    chk("lu_flush", 64'(flushes), 64'b0100);
    chk("lu_fwd1", 64'(fwd_rs1_sel), 64'b00);
    step();
    ex_valid = 0; ex_rd = 0; ex_rd_w_en = 0; ex_is_load = 0;
    mem_valid = 1; mem_rd = 5; mem_rd_w_en = 1;
    settle();
    chk("lu_next_fwd1", 64'(fwd_rs1_sel), 64'b10);
    chk("lu_next_wens", 64'(wens), 64'b11111);
    chk("lu_stall_cnt", stall_cnt, 64'd1);

    // 2. Back-to-back ALU forwarding
    step();
    idle();
    id_valid = 1; id_rs1 = 7; id_rs2 = 3; id_use_rs2 = 1;
    ex_valid = 1; ex_rd = 3; ex_rd_w_en = 1;
    mem_valid = 1; mem_rd = 3; mem_rd_w_en = 1;
    settle();
    chk("fwd_ex_over_mem", 64'(fwd_rs2_sel), 64'b01);
    chk("fwd_rs1_none", 64'(fwd_rs1_sel), 64'b00);
    ex_rd = 4;
    settle();
    chk("fwd_mem_only", 64'(fwd_rs2_sel), 64'b10);
    ex_rd = 0; mem_rd = 0; id_rs2 = 0;
    settle();
    chk("fwd_x0", 64'(fwd_rs2_sel), 64'b00);

    // 3. LSU wait of three cycles
    step();
    idle();
    mem_valid = 1; mem_lsu_req = 1; lsu_done = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lsu_wens", 64'(wens), 64'b00001);
      chk("lsu_flush", 64'(flushes), 64'b0001);
      step();
    end
    lsu_done = 1;
    settle();
    chk("lsu_done_wens", 64'(wens), 64'b11111);
    step();
    chk("lsu_stall_cnt", stall_cnt, 64'd4);
    // zero-wait access: done in the request cycle
    settle();
    chk("lsu_zero_wait", 64'(wens), 64'b11111);
    step();
    chk("lsu_zero_cnt", stall_cnt, 64'd4);

    // 4. LSU stall masks a pending redirect until lsu_done
    idle();
    mem_valid = 1; mem_lsu_req = 1;
    ex_valid = 1; ex_branch_taken = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("sim_wens", 64'(wens), 64'b00001);
      chk("sim_flush", 64'(flushes), 64'b0001);
      step();
    end
    lsu_done = 1;
    settle();
    chk("sim_redir_wens", 64'(wens), 64'b11111);
    chk("sim_redir_flush", 64'(flushes), 64'b1100);
    step();
    chk("sim_stall_cnt", stall_cnt, 64'd6);
    // multi-cycle EXU stall
    idle();
    ex_valid = 1; ex_busy = 1; ex_branch_taken = 1;
    settle();
    chk("exu_wens", 64'(wens), 64'b00011);
    chk("exu_flush", 64'(flushes), 64'b0010);
    step();
    chk("exu_stall_cnt", stall_cnt, 64'd7);

    // 5. LSU timeout with LSU_TIMEOUT=8
    idle();
    mem_valid = 1; mem_lsu_req = 1;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("tmo_wens", 64'(wens), 64'b00001);
      if (i == 7) chk("tmo_err_before", 64'(err), 64'd0);
      step();
    end
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_stall_cnt", stall_cnt, 64'd15);
    settle();
    chk("tmo_wens_err", 64'(wens), 64'b00000);
    chk("tmo_flush_err", 64'(flushes), 64'b1111);
    wb_valid = 1; lsu_done = 1;
    step();
    chk("tmo_frozen_stall", stall_cnt, 64'd15);
    chk("tmo_frozen_retire", retire_cnt, 64'd0);
    chk("tmo_err_held", 64'(err), 64'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    idle();
    chk("tmo_rst_err", 64'(err), 64'd0);
    chk("tmo_rst_stall", stall_cnt, 64'd0);
    settle();
    chk("tmo_rst_run", 64'(wens), 64'b11111);

    // 6. Ebreak after ten retirements
    step();
    wb_valid = 1;
    for (int i = 0; i < 10; i++) step();
    chk("eb_retire10", retire_cnt, 64'd10);
    wb_ebreak = 1;
    step();
    chk("eb_retire", retire_cnt, 64'd11);
    chk("eb_halted", 64'(halted), 64'd1);
    wb_ebreak = 0;
    ex_valid = 1; ex_busy = 1; mem_valid = 1; mem_lsu_req = 1;
    settle();
    chk("eb_wens", 64'(wens), 64'b00000);
    chk("eb_flush", 64'(flushes), 64'b1111);
    step();
    chk("eb_retire_frozen", retire_cnt, 64'd11);
    chk("eb_stall_frozen", stall_cnt, 64'd0);
    chk("eb_halt_held", 64'(halted), 64'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("eb_rst_halted", 64'(halted), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
